// File: rtl/matmul_link_ctrl.sv
// Serial-link controller for the matrix multiplier: baud enables, size/A/B byte capture, compute handshake, result transmit.
// Build option: define MATMUL_SIZE_CHECK_EN to reject out-of-range size bytes (size_err) instead of saturating them.

module matmul_link_ctrl #(
    parameter int BASE_DIV = 16,
    parameter int MAX_DIM  = 3
) (
    input  logic                            bclk,
    input  logic                            rst,
    input  logic [1:0]                      b_sel,
    input  logic                            rx_valid,
    input  logic [7:0]                      rx_data,
    input  logic                            tx_busy,
    input  logic                            mult_done,
    input  logic [16*MAX_DIM*MAX_DIM-1:0]   mult_result,
    output logic                            baud_tick,
    output logic                            baud_tick8,
    output logic [2:0]                      current_state,
    output logic [3:0]                      matrix_size,
    output logic                            rx_enable,
    output logic                            mult_start,
    output logic                            read_enable_a,
    output logic                            read_enable_b,
    output logic                            tx_start,
    output logic                            size_err,
    output logic [8*MAX_DIM*MAX_DIM-1:0]    a_data,
    output logic [8*MAX_DIM*MAX_DIM-1:0]    b_data,
    output logic [7:0]                      tx_data
);

    localparam int SUB_W = $clog2(BASE_DIV) + 1;

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        RECEIVE_SIZE     = 3'd1,
        RECEIVE_MATRIX_A = 3'd2,
        RECEIVE_MATRIX_B = 3'd3,
        COMPUTE          = 3'd4,
        SEND_RESULT      = 3'd5
    } state_t;

    state_t state, state_next;

    logic [SUB_W-1:0] sub_cnt, sub_last;
    logic [2:0]       eighth_cnt;
    logic [1:0]       b_sel_q;

    // Each baud_tick8 period is D/8 = BASE_DIV/8 << b_sel cycles; baud_tick lands on every 8th one.
    always_comb begin
        sub_last = SUB_W'(BASE_DIV / 8 - 1);
        case (b_sel)
            2'd0:    sub_last = SUB_W'(BASE_DIV / 8 - 1);
            2'd1:    sub_last = SUB_W'(BASE_DIV / 4 - 1);
            2'd2:    sub_last = SUB_W'(BASE_DIV / 2 - 1);
            default: sub_last = SUB_W'(BASE_DIV - 1);
        endcase
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            sub_cnt    <= '0;
            eighth_cnt <= '0;
            b_sel_q    <= '0;
            baud_tick8 <= 1'b0;
            baud_tick  <= 1'b0;
        end else if (b_sel != b_sel_q) begin
            b_sel_q    <= b_sel;
            sub_cnt    <= '0;
            eighth_cnt <= '0;
            baud_tick8 <= 1'b0;
            baud_tick  <= 1'b0;
        end else begin
            baud_tick8 <= (sub_cnt == sub_last);
            baud_tick  <= (sub_cnt == sub_last) && (eighth_cnt == 3'd7);
            if (sub_cnt == sub_last) begin
                sub_cnt    <= '0;
                eighth_cnt <= eighth_cnt + 3'd1;
            end else begin
                sub_cnt <= sub_cnt + SUB_W'(1);
            end
        end
    end

    logic [3:0] elem_cnt;
    logic [7:0] byte_idx;
    logic [7:0] nn;
    logic [7:0] total_bytes;
    logic       last_elem;
    logic       send_done;
    logic       can_send;
    logic       size_ok;
    logic [3:0] size_val;

    assign nn          = 8'(matrix_size) * 8'(matrix_size);
    assign total_bytes = {nn[6:0], 1'b0};
    assign last_elem   = ({4'd0, elem_cnt} == nn - 8'd1);
    assign send_done   = (byte_idx == total_bytes);

    // rx_valid is a one-cycle strobe with no back-pressure; a byte is taken only in the receive states.
    // A transmit start is a one-cycle tx_start with tx_data, issued only when tx_busy is low and the
    // previous cycle issued nothing, so the transmitter always gets a cycle to raise tx_busy.
    assign can_send = (state == SEND_RESULT) && !send_done && !tx_busy && !tx_start;

    always_comb begin
        size_ok  = 1'b1;
        size_val = rx_data[3:0];
`ifdef MATMUL_SIZE_CHECK_EN
        size_ok  = (rx_data != 8'd0) && (rx_data <= 8'(MAX_DIM));
        size_val = rx_data[3:0];
`else
        size_ok  = 1'b1;
        if (rx_data == 8'd0)
            size_val = 4'd1;
        else if (rx_data > 8'(MAX_DIM))
            size_val = 4'(MAX_DIM);
        else
            size_val = rx_data[3:0];
`endif
    end

    always_ff @(posedge bclk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:             state_next = RECEIVE_SIZE;
            RECEIVE_SIZE:     state_next = (rx_valid && size_ok) ? RECEIVE_MATRIX_A : RECEIVE_SIZE;
            RECEIVE_MATRIX_A: state_next = (rx_valid && last_elem) ? RECEIVE_MATRIX_B : RECEIVE_MATRIX_A;
            RECEIVE_MATRIX_B: state_next = (rx_valid && last_elem) ? COMPUTE : RECEIVE_MATRIX_B;
            COMPUTE:          state_next = mult_done ? SEND_RESULT : COMPUTE;
            SEND_RESULT:      state_next = (send_done && !tx_start && !tx_busy) ? IDLE : SEND_RESULT;
            default:          state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_enable     = 1'b0;
        mult_start    = 1'b0;
        read_enable_a = 1'b0;
        read_enable_b = 1'b0;
        case (state)
            RECEIVE_SIZE, RECEIVE_MATRIX_A, RECEIVE_MATRIX_B: rx_enable = 1'b1;
            COMPUTE: begin
                mult_start    = 1'b1;
                read_enable_a = 1'b1;
                read_enable_b = 1'b1;
            end
            default: ;
        endcase
    end

    assign current_state = state;

    always_ff @(posedge bclk) begin
        if (rst) begin
            matrix_size <= '0;
            elem_cnt    <= '0;
            byte_idx    <= '0;
            a_data      <= '0;
            b_data      <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                RECEIVE_SIZE: begin
                    if (rx_valid && size_ok) begin
                        matrix_size <= size_val;
                        elem_cnt    <= '0;
                    end
                end
                RECEIVE_MATRIX_A: begin
                    if (rx_valid) begin
                        a_data[{elem_cnt, 3'b000} +: 8] <= rx_data;
                        elem_cnt <= last_elem ? 4'd0 : elem_cnt + 4'd1;
                    end
                end
                RECEIVE_MATRIX_B: begin
                    if (rx_valid) begin
                        b_data[{elem_cnt, 3'b000} +: 8] <= rx_data;
                        elem_cnt <= last_elem ? 4'd0 : elem_cnt + 4'd1;
                    end
                end
                COMPUTE: byte_idx <= '0;
                SEND_RESULT: begin
                    if (can_send) begin
                        tx_start <= 1'b1;
                        tx_data  <= mult_result[{byte_idx, 3'b000} +: 8];
                        byte_idx <= byte_idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MATMUL_SIZE_CHECK_EN
    always_ff @(posedge bclk) begin
        if (rst) size_err <= 1'b0;
        else     size_err <= (state == RECEIVE_SIZE) && rx_valid && !size_ok;
    end
`else
    assign size_err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_link_ctrl.sv
// Self-checking bench for matmul_link_ctrl: baud and size tables, directed and randomized
// transactions against a queue-based model, transmit back-pressure and mid-send reset.

module tb_matmul_link_ctrl;

    localparam int NE = 9;

    logic          bclk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    b_sel = 2'd0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          tx_busy = 1'b0;
    logic          mult_done = 1'b0;
    logic [143:0]  mult_result = '0;
    logic          baud_tick, baud_tick8;
    logic [2:0]    current_state;
    logic [3:0]    matrix_size;
    logic          rx_enable, mult_start, read_enable_a, read_enable_b, tx_start, size_err;
    logic [71:0]   a_data, b_data;
    logic [7:0]    tx_data;

    matmul_link_ctrl #(.BASE_DIV(16), .MAX_DIM(3)) dut (
        .bclk(bclk), .rst(rst), .b_sel(b_sel), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_busy(tx_busy), .mult_done(mult_done), .mult_result(mult_result),
        .baud_tick(baud_tick), .baud_tick8(baud_tick8), .current_state(current_state),
        .matrix_size(matrix_size), .rx_enable(rx_enable), .mult_start(mult_start),
        .read_enable_a(read_enable_a), .read_enable_b(read_enable_b), .tx_start(tx_start),
        .size_err(size_err), .a_data(a_data), .b_data(b_data), .tx_data(tx_data)
    );

    always #5 bclk = ~bclk;

    typedef struct { logic [1:0] sel; int div; } baud_vec_t;
    typedef struct { logic [7:0] raw; logic [3:0] sat; } size_vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  a_mem [NE];
    logic [7:0]  b_mem [NE];
    logic [15:0] mres [NE];
    logic [7:0]  exp_q [$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge bclk);
        @(negedge bclk);
    endtask

    function automatic logic [71:0] pack8(input logic [7:0] m [NE]);
        logic [71:0] r;
        r = '0;
        for (int i = 0; i < NE; i++) r[8*i +: 8] = m[i];
        return r;
    endfunction

    function automatic logic [3:0] model_size(input logic [7:0] raw);
        if (raw == 8'd0) return 4'd1;
        if (raw > 8'd3)  return 4'd3;
        return raw[3:0];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NE; i++) begin
            a_mem[i] = 8'd0;
            b_mem[i] = 8'd0;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int c;
        c = 0;
        while (current_state !== s && c < budget) begin
            tick();
            c++;
        end
        check(name, 72'(current_state), 72'(s));
    endtask

    task automatic send_byte(input logic [7:0] v);
        rx_data  = v;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic run_txn(input logic [7:0] raw, input bit directed, input bit busy20, input int abort_after);
        logic [3:0] n;
        logic [7:0] v;
        logic [7:0] e;
        int nb, busy_cnt, starts;
        bit prev_busy, prev_start, done;
        n  = model_size(raw);
        nb = int'(n) * int'(n);
        wait_state(3'd1, 10, "enter_rx_size");
        gap();
        send_byte(raw);
        check("size_latched", 72'(matrix_size), 72'(n));
        check("state_after_size", 72'(current_state), 72'(3'd2));
        for (int i = 0; i < nb; i++) begin
            gap();
            v = directed ? 8'(i + 1) : 8'($urandom);
            send_byte(v);
            a_mem[i] = v;
        end
        check("state_after_a", 72'(current_state), 72'(3'd3));
        check("a_data", a_data, pack8(a_mem));
        if (directed) check("a_data_low32", 72'(a_data[31:0]), 72'(32'h04030201));
        for (int i = 0; i < nb; i++) begin
            gap();
            v = directed ? 8'(i + 5) : 8'($urandom);
            send_byte(v);
            b_mem[i] = v;
        end
        check("state_compute", 72'(current_state), 72'(3'd4));
        check("b_data", b_data, pack8(b_mem));
        if (directed) check("b_data_low32", 72'(b_data[31:0]), 72'(32'h08070605));
        check("mult_start", 72'(mult_start), 72'(1'b1));
        check("read_enables", 72'({read_enable_a, read_enable_b}), 72'(2'b11));
        check("rx_enable_off", 72'(rx_enable), 72'(1'b0));
        send_byte(8'hEE);
        check("stray_rx_a", a_data, pack8(a_mem));
        check("stray_rx_b", b_data, pack8(b_mem));
        check("hold_compute", 72'(current_state), 72'(3'd4));

        for (int i = 0; i < NE; i++) mres[i] = 16'($urandom);
        if (directed) begin
            mres[0] = 16'h0013; mres[1] = 16'h0016; mres[2] = 16'h002B; mres[3] = 16'h0032;
        end
        for (int i = 0; i < NE; i++) mult_result[16*i +: 16] = mres[i];
        exp_q.delete();
        if (directed)
            exp_q = '{8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32, 8'h00};
        else
            for (int k = 0; k < 2 * nb; k++)
                exp_q.push_back((k % 2 == 1) ? mres[k/2][15:8] : mres[k/2][7:0]);

        tx_busy   = busy20;
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        check("state_send", 72'(current_state), 72'(3'd5));
        if (busy20) begin
            for (int j = 0; j < 20; j++) begin
                tick();
                check("no_start_while_busy", 72'(tx_start), 72'(1'b0));
            end
            tx_busy = 1'b0;
        end

        busy_cnt = 0;
        starts   = 0;
        done     = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            prev_busy  = tx_busy;
            prev_start = tx_start;
            tick();
            if (current_state == 3'd0) begin
                check("idle_only_when_not_busy", 72'({prev_busy, prev_start}), 72'(2'b00));
                done = 1'b1;
            end else begin
                if (tx_start) begin
                    check("start_spacing", 72'({prev_busy, prev_start}), 72'(2'b00));
                    if (exp_q.size() == 0) begin
                        check("extra_tx_start", 72'(starts), 72'(2 * nb));
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", 72'(tx_data), 72'(e));
                    end
                    starts++;
                    if (abort_after != 0 && starts == abort_after) begin
                        rst = 1'b1;
                        tx_busy = 1'b0;
                        tick();
                        check("abort_state", 72'(current_state), 72'(3'd0));
                        check("abort_tx_start", 72'(tx_start), 72'(1'b0));
                        check("abort_a_data", a_data, 72'(0));
                        check("abort_b_data", b_data, 72'(0));
                        tick();
                        check("abort_no_start", 72'(tx_start), 72'(1'b0));
                        rst = 1'b0;
                        clear_model();
                        return;
                    end
                    busy_cnt = $urandom_range(0, 3);
                end else if (busy_cnt > 0) begin
                    busy_cnt--;
                end
                tx_busy = (busy_cnt > 0);
            end
        end
        tx_busy = 1'b0;
        check("send_finished", 72'(done), 72'(1'b1));
        check("tx_start_count", 72'(starts), 72'(2 * nb));
        check("exp_q_drained", 72'(exp_q.size()), 72'(0));
    endtask

    initial begin
        baud_vec_t bt [4];
        size_vec_t st [7];
        int c, n8, first8;
        logic [7:0] raw;

        bt = '{'{2'd1, 32}, '{2'd2, 64}, '{2'd3, 128}, '{2'd0, 16}};
        st = '{'{8'd0, 4'd1}, '{8'd1, 4'd1}, '{8'd2, 4'd2}, '{8'd3, 4'd3},
               '{8'd4, 4'd3}, '{8'd5, 4'd3}, '{8'd255, 4'd3}};
        clear_model();

        repeat (3) tick();
        check("rst_state", 72'(current_state), 72'(3'd0));
        check("rst_size", 72'(matrix_size), 72'(0));
        check("rst_a_data", a_data, 72'(0));
        check("rst_b_data", b_data, 72'(0));
        check("rst_tx", 72'({tx_start, tx_data}), 72'(0));
        check("rst_strobes", 72'({baud_tick, baud_tick8, rx_enable, mult_start,
                                  read_enable_a, read_enable_b, size_err}), 72'(0));
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            b_sel = bt[i].sel;
            c = 0;
            do begin
                tick();
                c++;
            end while (!baud_tick && c < 3 * bt[i].div);
            check("baud_restart_window", 72'((c >= bt[i].div) && (c <= bt[i].div + 2)), 72'(1'b1));
            check("tick_has_tick8", 72'(baud_tick8), 72'(1'b1));
            c = 0; n8 = 0; first8 = 0;
            do begin
                tick();
                c++;
                if (baud_tick8) begin
                    n8++;
                    if (first8 == 0) first8 = c;
                end
            end while (!baud_tick && c < 3 * bt[i].div);
            check("baud_period", 72'(c), 72'(bt[i].div));
            check("tick8_period", 72'(first8), 72'(bt[i].div / 8));
            check("tick8_per_tick", 72'(n8), 72'(8));
            check("tick_coincident", 72'(baud_tick8), 72'(1'b1));
        end
        b_sel = 2'd0;

        for (int i = 0; i < 7; i++) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            wait_state(3'd1, 10, "size_tbl_enter");
            send_byte(st[i].raw);
`ifdef MATMUL_SIZE_CHECK_EN
            if (st[i].raw >= 8'd1 && st[i].raw <= 8'd3) begin
                check("size_tbl_ok", 72'(matrix_size), 72'(st[i].raw));
                check("size_tbl_state", 72'(current_state), 72'(3'd2));
            end else begin
                check("size_err_pulse", 72'(size_err), 72'(1'b1));
                check("size_err_state", 72'(current_state), 72'(3'd1));
                check("size_err_keep", 72'(matrix_size), 72'(0));
                tick();
                check("size_err_one_cycle", 72'(size_err), 72'(1'b0));
            end
`else
            check("size_tbl_sat", 72'(matrix_size), 72'(st[i].sat));
            check("size_tbl_state", 72'(current_state), 72'(3'd2));
            check("size_err_tied", 72'(size_err), 72'(1'b0));
`endif
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();

        run_txn(8'h02, 1'b1, 1'b1, 0);
`ifdef MATMUL_SIZE_CHECK_EN
        run_txn(8'h03, 1'b0, 1'b0, 0);
`else
        run_txn(8'h05, 1'b0, 1'b0, 0);
`endif
        for (int t = 0; t < 6; t++) begin
`ifdef MATMUL_SIZE_CHECK_EN
            raw = 8'($urandom_range(1, 3));
`else
            raw = 8'($urandom_range(0, 4));
            if (raw == 8'd4) raw = 8'($urandom_range(4, 255));
`endif
            run_txn(raw, 1'b0, ($urandom_range(0, 3) == 0), 0);
        end
        run_txn(8'h02, 1'b0, 1'b0, 3);
        run_txn(8'h03, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_link_ctrl.md
MATMUL_LINK_CTRL -- requirements
Module: matmul_link_ctrl

Interface
REQ-001 Parameter BASE_DIV, 16, bclk cycles per bit at b_sel=00; SHALL be a multiple of 8.
REQ-002 Parameter MAX_DIM, 3, maximum square matrix dimension; memory depth is MAX_DIM*MAX_DIM = 9 bytes per matrix.
REQ-003 Reset rst is synchronous and active-high; clock is bclk.
REQ-004 Port bclk  in  1  block clock.
REQ-005 Port rst  in  1  synchronous active-high reset.
REQ-006 Port b_sel  in  2  baud select.
REQ-007 Port rx_valid/rx_data  in  1/8  one-cycle received-byte strobe and byte.
REQ-008 Port tx_busy  in  1  transmitter busy.
REQ-009 Port mult_done  in  1  multiplier finished.
REQ-010 Port mult_result  in  144  nine 16-bit products; element i at [16i+:16].
REQ-011 Port baud_tick/baud_tick8  out  1/1  bit-rate and 8x bit-rate enables.
REQ-012 Port current_state  out  3  FSM state.
REQ-013 Port matrix_size  out  4  latched dimension n.
REQ-014 Port rx_enable, mult_start, read_enable_a, read_enable_b, tx_start, size_err  out  1 each.
REQ-015 Port a_data/b_data  out  72/72  packed matrices; element i at [8i+:8].
REQ-016 Port tx_data  out  8  byte to transmit.

Function
REQ-017 Divisor D SHALL be BASE_DIV*{1,2,4,8} for b_sel {00,01,10,11}; baud_tick8 pulses one cycle every D/8 cycles, baud_tick every D cycles, coincident with every 8th baud_tick8; the counter restarts when b_sel changes.
REQ-018 States SHALL be IDLE=0, RECEIVE_SIZE=1, RECEIVE_MATRIX_A=2, RECEIVE_MATRIX_B=3, COMPUTE=4, SEND_RESULT=5; other codes return to IDLE.
REQ-019 IDLE SHALL go to RECEIVE_SIZE on the next edge unconditionally.
REQ-020 RECEIVE_SIZE: on rx_valid, latch matrix_size, clear element counter, go to RECEIVE_MATRIX_A.
REQ-021 RECEIVE_MATRIX_A/B: each rx_valid writes rx_data to element index = counter (row-major, index r*n+c); counter increments; after the n*n-th byte, counter clears and the state advances (A->B, B->COMPUTE); written data is visible on a_data/b_data the next cycle.
REQ-022 rx_enable SHALL be high in states 1-3; rx_valid in any other state SHALL be ignored.
REQ-023 COMPUTE: mult_start, read_enable_a and read_enable_b high while in state; on mult_done go to SEND_RESULT with byte index 0.
REQ-024 SEND_RESULT SHALL send 2*n*n bytes, byte k = mult_result[8k+:8] (little-endian per element); tx_data and a one-cycle tx_start are registered together when tx_busy is low and no start was issued the previous cycle.
REQ-025 After the last byte's tx_start, the FSM SHALL wait for tx_busy low, then return to IDLE.
REQ-026 Memories SHALL retain contents between transactions; unwritten elements keep old values.

Reset
REQ-027 On rst: state IDLE, all counters 0, matrix_size 0, all memory elements 0, tx_data 0, all strobes/enables 0, baud counter 0.
REQ-028 Reset mid-transaction SHALL abort immediately with no further tx_start.

Configuration
REQ-029 With MATMUL_SIZE_CHECK_EN defined, a size byte of 0 or >MAX_DIM SHALL be discarded, pulse size_err one cycle, and stay in RECEIVE_SIZE.
REQ-030 Without MATMUL_SIZE_CHECK_EN, size SHALL saturate (0->1, >MAX_DIM->MAX_DIM) and be accepted; size_err tied 0.

Verification
REQ-031 b_sel=01, BASE_DIV=16 -> baud_tick every 32 cycles, baud_tick8 every 4.
REQ-032 Size 02, A bytes 01 02 03 04, B bytes 05 06 07 08 -> a_data[31:0]=04030201, b_data[31:0]=08070605, state 4, mult_start high.
REQ-033 mult_done with mult_result elements 0..3 = 0013,0016,002B,0032 -> 8 tx_starts, bytes 13 00 16 00 2B 00 32 00, then IDLE.
REQ-034 Size 05 with macro -> size_err pulse, state stays 1; without macro -> matrix_size 3, expects 9 bytes.
REQ-035 rst asserted during SEND_RESULT after 3 bytes -> next cycle state 0, tx_start 0, a_data 0.
REQ-036 tx_busy held high 20 cycles in SEND_RESULT -> no tx_start until it falls.
